huffman_coder: RTL and testbench

// Static Huffman encoder for 3-bit symbols, as a Tiny Tapeout user tile.
// A symbol is accepted on a start strobe and looked up in a fixed canonical

---
 rtl/huffman_coder.sv | 139 +++++++++++++
 tb/tb_huffman_coder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_coder.sv
`default_nettype none
// ============================================================================
// Module      : huffman_coder
// Description : Static canonical Huffman encoder for 3-bit symbols. Accepts a
//               symbol on a start strobe, emits its codeword MSB-first one bit
//               per clock, and presents {length, codeword} in parallel on the
//               bidirectional pins (always driven as outputs).
// Revision    : 1.0 - initial release
// ============================================================================
module huffman_coder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // Two-state controller: waiting for a symbol, or shifting its codeword out.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [7:0] c_uio_all_out = 8'hFF;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [4:0] r_shift;          // codeword left-aligned, MSB is the bit on the wire
  logic [4:0] w_shift_nxt;
  logic [2:0] r_remaining;      // bits still to be presented, including the current one
  logic [2:0] w_remaining_nxt;
  logic [7:0] r_code_out;       // {L, codeword right-aligned} of the last accepted symbol
  logic [7:0] w_code_out_nxt;
  logic       r_done;
  logic       w_done_nxt;
  logic [3:0] r_count;          // completed symbols, wraps 15 -> 0
  logic [3:0] w_count_nxt;

  logic [2:0] w_sym;
  logic       w_start;
  logic [2:0] w_len;
  logic [4:0] w_cw_right;
  logic [4:0] w_cw_left;
  logic       w_bit_valid;
  logic       w_serial;
  logic       w_unused;

  assign w_sym   = ui_in[2:0];
  assign w_start = ui_in[3];

  // The upper input bits and the bidirectional inputs carry no function.
  assign w_unused = &{1'b0, ui_in[7:4], uio_in};

  // Fixed code table; the left-aligned form feeds the shifter directly so no
  // variable shift is needed at load time.
  always_comb begin
    w_len      = 3'd2;
    w_cw_right = 5'b00000;
    w_cw_left  = 5'b00000;
    unique case (w_sym)
      3'd0: begin w_len = 3'd2; w_cw_right = 5'b00000; w_cw_left = 5'b00000; end
      3'd1: begin w_len = 3'd2; w_cw_right = 5'b00001; w_cw_left = 5'b01000; end
      3'd2: begin w_len = 3'd3; w_cw_right = 5'b00100; w_cw_left = 5'b10000; end
      3'd3: begin w_len = 3'd3; w_cw_right = 5'b00101; w_cw_left = 5'b10100; end
      3'd4: begin w_len = 3'd3; w_cw_right = 5'b00110; w_cw_left = 5'b11000; end
      3'd5: begin w_len = 3'd4; w_cw_right = 5'b01110; w_cw_left = 5'b11100; end
      3'd6: begin w_len = 3'd5; w_cw_right = 5'b11110; w_cw_left = 5'b11110; end
      3'd7: begin w_len = 3'd5; w_cw_right = 5'b11111; w_cw_left = 5'b11111; end
      default: begin w_len = 3'd2; w_cw_right = 5'b00000; w_cw_left = 5'b00000; end
    endcase
  end

  // Next-state logic; with ena low every register reloads its own value.
  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_remaining_nxt = r_remaining;
    w_code_out_nxt  = r_code_out;
    w_done_nxt      = r_done;
    w_count_nxt     = r_count;
    if (ena) begin
      w_done_nxt = 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            w_shift_nxt     = w_cw_left;
            w_remaining_nxt = w_len;
            w_code_out_nxt  = {w_len, w_cw_right};
            w_state_nxt     = EMIT;
          end
        end
        EMIT: begin
          w_shift_nxt     = {r_shift[3:0], 1'b0};
          w_remaining_nxt = r_remaining - 3'd1;
          if (r_remaining == 3'd1) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
            w_count_nxt = r_count + 4'd1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; reset aborts any emission in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shift     <= 5'd0;
      r_remaining <= 3'd0;
      r_code_out  <= 8'd0;
      r_done      <= 1'b0;
      r_count     <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_remaining <= w_remaining_nxt;
      r_code_out  <= w_code_out_nxt;
      r_done      <= w_done_nxt;
      r_count     <= w_count_nxt;
    end
  end

  // A bit is on the wire for every cycle spent in EMIT; serial is forced low otherwise.
  assign w_bit_valid = (r_state == EMIT);
  assign w_serial    = w_bit_valid & r_shift[4];

  assign uo_out  = {r_count, r_done, w_bit_valid, w_bit_valid, w_serial};
  assign uio_out = r_code_out;
  assign uio_oe  = c_uio_all_out;

endmodule
`default_nettype wire

// File: tb/tb_huffman_coder.sv
`default_nettype none
// ============================================================================
// Module      : tb_huffman_coder
// Description : Scoreboard testbench for huffman_coder. Stimulus pushes the
//               expected codeword records; a negedge monitor checks them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_huffman_coder;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  huffman_coder dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] len;
    logic [4:0] cw;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;
  int   c_lens[8] = '{2, 2, 3, 3, 3, 4, 5, 5};

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Canonical code built from the length list: each code is previous+1,
  // shifted left by the growth in length.
  function automatic void canon(input int sym, output int len, output int code);
    code = 0;
    for (int i = 1; i <= sym; i++) code = (code + 1) << (c_lens[i] - c_lens[i-1]);
    len = c_lens[sym];
  endfunction

  task automatic push_exp(input int sym);
    int   l;
    int   c;
    exp_t e;
    canon(sym, l, c);
    model_cnt = (model_cnt + 1) % 16;
    e.len = 3'(l);
    e.cw  = 5'(c);
    e.cnt = 4'(model_cnt);
    exp_q.push_back(e);
  endtask

  // Advance in posedge+2 steps until the encoder is not busy.
  task automatic wait_idle(input bit rand_ena);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (!uo_out[2]) ok = 1'b1;
      else begin
        @(posedge clk); #2;
        ena         = rand_ena ? ($urandom_range(0, 3) != 0) : 1'b1;
        ui_in[7:4]  = 4'($urandom);
        uio_in      = 8'($urandom);
      end
    end
    if (!ok) fail("idle_timeout");
  endtask

  task automatic send(input logic [2:0] sym, input bit rand_ena);
    wait_idle(rand_ena);
    ena   = 1'b1;
    ui_in = {4'($urandom), 1'b1, sym};
    push_exp(int'(sym));
    @(posedge clk); #2;
    ui_in = {4'($urandom), 1'b0, 3'($urandom)};
  endtask

  // Monitor: consumes expected records as codewords appear on the outputs.
  logic [7:0] p_uo;
  logic [7:0] p_uio;
  bit   p_ena  = 1'b0;
  bit   p_rst  = 1'b0;
  bit   p_done = 1'b0;
  bit   open   = 1'b0;
  int   idx    = 0;
  exp_t cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      check_eq("reset_uo", uo_out, 8'h00);
      check_eq("reset_uio", uio_out, 8'h00);
      open = 1'b0;
    end else begin
      check_eq("busy_eq_valid", uo_out[2], uo_out[1]);
      check_eq("uio_oe", uio_oe, 8'hFF);
      if (!uo_out[1]) check_eq("serial_idle", uo_out[0], 1'b0);
      if (p_rst && !p_ena) begin
        check_eq("freeze_uo", uo_out, p_uo);
        check_eq("freeze_uio", uio_out, p_uio);
      end
      if (uo_out[1]) begin
        if (!open) begin
          if (exp_q.size() == 0) fail("unexpected_emit");
          else begin
            cur  = exp_q.pop_front();
            open = 1'b1;
            idx  = 0;
            check_eq("code_parallel", uio_out, {cur.len, cur.cw});
          end
        end
        if (open) begin
          if (idx < int'(cur.len)) begin
            check_eq("serial_bit", uo_out[0], cur.cw[int'(cur.len) - 1 - idx]);
            if (ena) idx++;
          end else fail("too_many_bits");
        end
      end
      if (uo_out[3]) begin
        if (p_done && p_ena && p_rst) fail("done_width");
        else if (!(p_done && !p_ena && p_rst)) begin
          if (!open) fail("done_without_symbol");
          else begin
            check_eq("bits_emitted", idx, int'(cur.len));
            check_eq("symbol_count", uo_out[7:4], cur.cnt);
            open = 1'b0;
          end
        end
      end
    end
    p_uo   = uo_out;
    p_uio  = uio_out;
    p_ena  = ena;
    p_rst  = rst_n;
    p_done = uo_out[3];
  end

  initial begin
    bit seen;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'hFF;
    uio_in = 8'hFF;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_uo_direct", uo_out, 8'h00);
    check_eq("rst_uio_direct", uio_out, 8'h00);
    check_eq("rst_oe_direct", uio_oe, 8'hFF);
    ui_in = 8'h00;
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Single symbols.
    send(3'd0, 1'b0);
    send(3'd6, 1'b0);

    // Start held high across two symbols; the symbol change during EMIT is ignored.
    wait_idle(1'b0);
    ui_in = {4'($urandom), 1'b1, 3'd2};
    push_exp(2);
    push_exp(5);
    @(posedge clk); #2;
    ui_in = {4'($urandom), 1'b1, 3'd5};
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (uo_out[3]) seen = 1'b1;
      else begin @(posedge clk); #2; end
    end
    if (!seen) fail("held_done_timeout");
    check_eq("gap_valid_low", uo_out[1], 1'b0);
    @(posedge clk); #2;
    check_eq("reaccept_valid", uo_out[1], 1'b1);
    check_eq("reaccept_first_bit", uo_out[0], 1'b1);
    ui_in[3] = 1'b0;

    // Freeze mid-way through symbol 7.
    send(3'd7, 1'b0);
    @(posedge clk); #2;
    ena = 1'b0;
    repeat (3) begin @(posedge clk); #2; end
    ena = 1'b1;

    // Random symbols with random enable gaps; carries the count through its wrap.
    for (int n = 0; n < 12; n++) send(3'($urandom), 1'b1);
    wait_idle(1'b0);
    ena = 1'b1;
    repeat (2) begin @(posedge clk); #2; end

    // Reset asserted mid-emission aborts it.
    send(3'd6, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_uo", uo_out, 8'h00);
    check_eq("abort_uio", uio_out, 8'h00);
    exp_q.delete();
    model_cnt = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #2;

    send(3'd3, 1'b0);
    wait_idle(1'b0);
    repeat (3) begin @(posedge clk); #2; end
    check_eq("queue_drained", exp_q.size(), 0);
    check_eq("no_open_symbol", open, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
